// File: rtl/spi_mem_if.sv
// SPI pin bundle between an SPI master and the spi_mem_slave endpoint.
// Latency: none, wires only.
// Backpressure: none; the master paces every bit with SS_n/MOSI.
interface spi_mem_if;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic active;

  modport master (output SS_n, output MOSI, input MISO, input active);
  modport slave  (input SS_n, input MOSI, output MISO, output active);
endinterface

// File: rtl/spi_mem_slave.sv
// SPI-slave memory endpoint: opcode, address and burst data framed by SS_n, backed by a single-port RAM.
// Latency: first MISO bit after edge 3 of a read frame; writes land at the last bit edge of each word.
// Backpressure: none; the master clocks one bit per clk while SS_n is low, words stream without gaps.
module spi_mem_slave #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int AUTO_INC = 1
) (
  input  logic     clk,
  input  logic     rst,
  spi_mem_if.slave spi
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int SR_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(SR_W + 1);

  typedef enum logic [2:0] {IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_addr, rd_addr, rd_nxt;
  logic [SR_W-2:0]   rx_sr;
  logic [SR_W-1:0]   rx_nxt;
  logic [DATA_W-1:0] rd_q, tx_sr;
  logic [CNT_W-1:0]  cnt;
  logic              op_hi;
  logic              frame_blk;  // set by rst: ignore the rest of the current frame
  logic              addr_done, word_done, rd_first, rd_issue, wr_fire;

  // Bit/word boundary decode and read/write strobes
  always_comb begin
    rx_nxt    = {rx_sr, spi.MOSI};
    addr_done = (cnt == CNT_W'(ADDR_W - 1));
    word_done = (cnt == CNT_W'(DATA_W - 1));
    rd_nxt    = (AUTO_INC != 0) ? rd_addr + ADDR_W'(1) : rd_addr;
    rd_first  = !spi.SS_n && (state == CMD) && op_hi && spi.MOSI;
    rd_issue  = !spi.SS_n && (state == RD_DATA) && word_done;
    wr_fire   = !spi.SS_n && (state == WR_DATA) && word_done;
  end

  // Next-state: SS_n high always aborts to IDLE; opcode decoded on edge 2
  always_comb begin
    state_nxt = state;
    if (spi.SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (!frame_blk) state_nxt = CMD;
        CMD: begin
          case ({op_hi, spi.MOSI})
            2'b00:   state_nxt = WR_ADDR;
            2'b01:   state_nxt = WR_DATA;
            2'b10:   state_nxt = RD_ADDR;
            default: state_nxt = RD_DATA;
          endcase
        end
        default: state_nxt = state;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Serial datapath: shift-in, address registers, MISO shifter, counters
  always_ff @(posedge clk) begin
    if (rst) begin
      spi.MISO   <= 1'b0;
      spi.active <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      cnt        <= '0;
      op_hi      <= 1'b0;
      frame_blk  <= 1'b1;
    end else begin
      spi.active <= (state_nxt != IDLE);
      spi.MISO   <= 1'b0;
      if (spi.SS_n) begin
        frame_blk <= 1'b0;
        cnt       <= '0;
      end else begin
        case (state)
          IDLE: begin
            op_hi <= spi.MOSI;
            cnt   <= '0;
          end
          CMD: cnt <= '0;
          WR_ADDR, RD_ADDR: begin
            // Counter saturates at ADDR_W so trailing bits are ignored
            if (cnt != CNT_W'(ADDR_W)) begin
              rx_sr <= rx_nxt[SR_W-2:0];
              cnt   <= cnt + CNT_W'(1);
              if (addr_done) begin
                if (state == WR_ADDR) wr_addr <= rx_nxt[ADDR_W-1:0];
                else                  rd_addr <= rx_nxt[ADDR_W-1:0];
              end
            end
          end
          WR_DATA: begin
            rx_sr <= rx_nxt[SR_W-2:0];
            if (word_done) begin
              cnt <= '0;
              if (AUTO_INC != 0) wr_addr <= wr_addr + ADDR_W'(1);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RD_DATA: begin
            // First bit of each word comes straight from the RAM output register
            if (cnt == '0) begin
              spi.MISO <= rd_q[DATA_W-1];
              tx_sr    <= {rd_q[DATA_W-2:0], 1'b0};
            end else begin
              spi.MISO <= tx_sr[DATA_W-1];
              tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
            end
            if (word_done) begin
              cnt     <= '0;
              rd_addr <= rd_nxt;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

  // Single-port RAM: write at word completion, synchronous read one edge ahead of use
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) mem[wr_addr] <= rx_nxt[DATA_W-1:0];
    if (!rst && (rd_first || rd_issue)) rd_q <= mem[rd_first ? rd_addr : rd_nxt];
  end

endmodule

// File: tb/tb_spi_mem_slave.sv
// Directed bench for spi_mem_slave: two instances (auto-increment on / off) share one driver.
// Latency: read data expected from the edge after the opcode; words compared via a scoreboard queue.
// Backpressure: none; the bench is the SPI master and drives one bit per clock.
module tb_spi_mem_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ss, mosi, sel1;
  logic miso, act;

  spi_mem_if if0 ();
  spi_mem_if if1 ();

  assign if0.SS_n = sel1 ? 1'b1 : ss;
  assign if1.SS_n = sel1 ? ss : 1'b1;
  assign if0.MOSI = mosi;
  assign if1.MOSI = mosi;
  assign miso     = sel1 ? if1.MISO : if0.MISO;
  assign act      = sel1 ? if1.active : if0.active;

  spi_mem_slave #(.DATA_W(8), .ADDR_W(8), .AUTO_INC(1)) dut0 (
    .clk (clk),
    .rst (rst),
    .spi (if0.slave)
  );

  spi_mem_slave #(.DATA_W(8), .ADDR_W(8), .AUTO_INC(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .spi (if1.slave)
  );

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  exp_q [$];
  logic [63:0] cap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, return at the next falling edge
  task automatic cyc(input logic s, input logic m);
    ss   = s;
    mosi = m;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full frame: 2 opcode bits, nbits payload MSB first, MISO captured from edge 3 on
  task automatic frame(input logic [1:0] op, input logic [63:0] pl, input int nbits);
    cap = '0;
    cyc(1'b0, op[1]);
    chk("active_rise", act, 1);
    cyc(1'b0, op[0]);
    for (int i = nbits - 1; i >= 0; i--) begin
      cyc(1'b0, pl[i]);
      cap = {cap[62:0], miso};
    end
    cyc(1'b1, 1'b0);
    chk("active_fall", act, 0);
    chk("miso_idle", miso, 0);
  endtask

  task automatic check_words(input int n, input string tag);
    logic [7:0] w;
    logic [7:0] e;
    for (int k = 0; k < n; k++) begin
      w = cap[8*(n-1-k) +: 8];
      if (exp_q.size() == 0) e = 8'hxx;
      else                   e = exp_q.pop_front();
      chk(tag, w, e);
    end
  endtask

  initial begin
    rst  = 1'b1;
    ss   = 1'b0;
    mosi = 1'b0;
    sel1 = 1'b0;
    @(negedge clk);

    // Reset with SS_n low and MOSI toggling
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk("rst_miso", miso, 0);
    chk("rst_active", act, 0);
    chk("rst_wr_addr", dut0.wr_addr, 8'h00);
    chk("rst_rd_addr", dut0.rd_addr, 8'h00);
    rst = 1'b0;
    cyc(1'b1, 1'b0);

    // Single write then read of 0xA5 at 0x10
    frame(2'b00, 64'h10, 8);
    frame(2'b01, 64'hA5, 8);
    frame(2'b10, 64'h10, 8);
    exp_q.push_back(8'hA5);
    frame(2'b11, 64'h0, 8);
    check_words(1, "single_rd");

    // Burst write across the top of the address space, burst read back
    frame(2'b00, 64'hFE, 8);
    frame(2'b01, 64'h112233, 24);
    chk("wrap_wr_addr", dut0.wr_addr, 8'h01);
    frame(2'b10, 64'hFE, 8);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    frame(2'b11, 64'h0, 24);
    check_words(3, "burst_rd");
    chk("wrap_rd_addr", dut0.rd_addr, 8'h01);

    // Address held: second word overwrites, burst read repeats
    sel1 = 1'b1;
    frame(2'b00, 64'h04, 8);
    frame(2'b01, 64'h5AC3, 16);
    chk("noinc_wr_addr", dut1.wr_addr, 8'h04);
    frame(2'b10, 64'h04, 8);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hC3);
    frame(2'b11, 64'h0, 16);
    check_words(2, "noinc_rd");
    sel1 = 1'b0;

    // Aborted write word: no memory write, wr_addr kept
    frame(2'b00, 64'h21, 8);
    frame(2'b01, 64'h66, 8);
    frame(2'b00, 64'h20, 8);
    frame(2'b01, 64'h77, 8);
    frame(2'b01, 64'h15, 5);
    chk("abort_wr_addr", dut0.wr_addr, 8'h21);
    frame(2'b10, 64'h21, 8);
    exp_q.push_back(8'h66);
    frame(2'b11, 64'h0, 8);
    check_words(1, "abort_wr_mem");

    // Aborted address: rd_addr kept
    frame(2'b10, 64'h20, 8);
    frame(2'b10, 64'h5, 3);
    chk("abort_rd_addr", dut0.rd_addr, 8'h20);
    exp_q.push_back(8'h77);
    frame(2'b11, 64'h0, 8);
    check_words(1, "abort_rd_data");

    // Reset in the middle of a read burst
    frame(2'b10, 64'h10, 8);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("pre_rst_miso", miso, 1);
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b0;
    chk("midrst_miso", miso, 0);
    chk("midrst_active", act, 0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("midrst_blk_active", act, 0);
    chk("midrst_blk_miso", miso, 0);
    cyc(1'b1, 1'b0);
    frame(2'b10, 64'h10, 8);
    exp_q.push_back(8'hA5);
    frame(2'b11, 64'h0, 8);
    check_words(1, "midrst_mem");
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
